// File: rtl/hazard_irq_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: IRQ FSM encoding and bubble PC.
// No logic, no latency, no flow control.
package hazard_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_PEND  = 2'd1,
        IRQ_BLOCK = 2'd2
    } irq_state_t;

    // Flushed IF/ID slots carry this PC+4, which reads as kernel mode in ID.
    localparam logic [31:0] KERNEL_BUBBLE_PC = 32'h8000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; count visible one cycle after the event.
// No backpressure: increments are dropped at all-ones, clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_irq_ctrl.sv
// Stall/flush controller for IF/ID, ID/EX and PC; sequences interrupt entry around redirects.
// Control outputs are same-cycle combinational; FSM and statistics counters update on the next edge.
module hazard_irq_ctrl
    import hazard_irq_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_pc_kernel,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             irq,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             irq_take,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    irq_state_t state_q;
    logic       lu;
    logic       lu_win;

    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Interrupt entry only on a real user-mode instruction that is not being redirected or stalled.
    assign irq_take = (state_q == IRQ_PEND) && !ex_branch_taken && !lu &&
                      !id_jump && !id_pc_kernel;

    assign lu_win = lu && !ex_branch_taken;

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (irq_take) begin
            if_id_flush = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_jump) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IRQ_IDLE;
        end else begin
            case (state_q)
                IRQ_IDLE:  if (irq)      state_q <= IRQ_PEND;
                IRQ_PEND:  if (irq_take) state_q <= IRQ_BLOCK;
                IRQ_BLOCK: if (!irq)     state_q <= IRQ_IDLE;
                default:                 state_q <= IRQ_IDLE;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (lu_win),
        .clr_i (cnt_clr),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (if_id_flush),
        .clr_i (cnt_clr),
        .cnt_o (flush_cnt)
    );

endmodule

// File: doc/hazard_irq_ctrl.md
# hazard_irq_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It drives the write-enable and flush inputs of the IF/ID and ID/EX pipeline registers and the PC write-enable, resolving load-use hazards, taken branches, ID-stage jumps and external interrupts. A small FSM sequences interrupt entry so it never collides with a redirect or stall. Two saturating counters expose stall and flush statistics to the peripheral bus.

## Interface
- CNT_W, 32: width of the statistics counters.

- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- id_jump  in  1  ID instruction is j/jal/jr/jalr (PC redirected from ID)
- id_pc_kernel  in  1  bit 31 of ID PC+4; 1 = kernel mode or bubble
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  destination register of the EX load
- ex_branch_taken  in  1  branch in EX resolved taken
- irq  in  1  level interrupt request from timer, synchronous to clk
- cnt_clr  in  1  synchronous clear of both counters
- pc_write  out  1  PC register write-enable
- if_id_write  out  1  IF/ID write-enable
- if_id_flush  out  1  IF/ID flush (loads bubble, PC+4 = 0x80000000)
- id_ex_flush  out  1  ID/EX flush (zeroes all control)
- irq_take  out  1  convert ID instruction into interrupt entry this cycle
- stall_cnt  out  CNT_W  cycles spent in load-use stall
- flush_cnt  out  CNT_W  cycles with if_id_flush asserted

## Operation
- Hazard terms (combinational): lu = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Priority, highest first: ex_branch_taken, irq_take, lu, id_jump.
- ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; lu and id_jump ignored.
- irq_take: pc_write=1, if_id_flush=1, id_ex_flush=0 (ID instruction becomes the interrupt jump-and-link, saving its PC to $k0).
- lu: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
- id_jump: if_id_flush=1 only.
- Default: pc_write=1, if_id_write=1, flushes 0, irq_take 0.
- IRQ FSM states IDLE, PEND, BLOCK:
  - IDLE -> PEND when irq=1.
  - PEND: irq_take=1 combinationally when ~ex_branch_taken & ~lu & ~id_jump & ~id_pc_kernel; then -> BLOCK. Otherwise stay PEND (request latched even if irq drops).
  - BLOCK: wait for irq=0, then -> IDLE; prevents re-entry on the same level.
- Bubbles carry PC+4 = 0x80000000, so id_pc_kernel also blocks irq_take on bubbles; no separate valid input.
- Counters: stall_cnt += 1 each cycle lu is the winning condition; flush_cnt += 1 each cycle if_id_flush=1. Both saturate at all-ones, cnt_clr takes priority over increment.

## Timing
- All five control outputs are Mealy, combinational from inputs and FSM state; same-cycle effect on the registers they drive.
- FSM state and counters registered; counters reflect events one cycle later.
- Reset (async, any state incl. PEND): state IDLE, stall_cnt=0, flush_cnt=0; with inputs at 0 outputs are pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, irq_take=0.
- Load-use stall lasts exactly one cycle: next cycle the load sits in MEM and ID/EX holds a bubble (ex_mem_read=0).
- irq_take is a single-cycle pulse per irq level assertion.
- Simultaneous lu and ex_branch_taken: branch wins, no stall counted.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, PEND=2'd1, BLOCK=2'd2), KERNEL_BUBBLE_PC=32'h80000000.
- Sub-module sat_counter (CNT_W, inc, clr) instantiated twice; rest in hazard_irq_ctrl.

## Test plan
- ex_mem_read=1, ex_rt=8, id_rs=8 -> pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle; stall_cnt 0->1.
- Same as above with ex_rt=0 -> no stall, all defaults.
- ex_branch_taken=1 with lu active -> both flushes 1, pc_write=1; flush_cnt +1, stall_cnt unchanged.
- irq=1 pulse 1 cycle while id_pc_kernel=1 for 3 cycles then 0 -> state PEND held, irq_take=1 on 4th cycle only, then BLOCK -> IDLE.
- irq held high 10 cycles -> exactly one irq_take; re-entry only after irq falls and rises again.
- Assert reset in PEND -> state IDLE, counters 0, irq_take=0; cnt_clr with stall_cnt at all-ones -> 0 next cycle.
